lcd_i2c_controller: RTL

//   Downstream of display_manager: accepts one byte per request (character or command),

---
 rtl/lcd_pkg.sv | 34 +++
 rtl/lcd_i2c_controller_if.sv | 20 ++
 rtl/lcd_us_timer.sv | 35 +++
 rtl/lcd_i2c_controller.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: PCF8574 frame layout, HD44780 init constants and controller state encodings
package lcd_pkg;

    localparam int FRAME_RS = 0;
    localparam int FRAME_RW = 1;
    localparam int FRAME_EN = 2;
    localparam int FRAME_BL = 3;

    localparam logic [3:0] INIT_NIB_8BIT = 4'h3;
    localparam logic [3:0] INIT_NIB_4BIT = 4'h2;
    localparam logic [7:0] CMD_FUNC_SET  = 8'h28;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_ENTRY     = 8'h06;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;

    typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, SEND, DELAY} top_state_t;
    typedef enum logic [2:0] {NIB_HI, ACK_HI, DONE_HI, NIB_LO, ACK_LO, DONE_LO} nib_state_t;

    // Steps 0..3 are lone nibbles carried in the high half; steps 4..7 are full bytes
    function automatic logic [7:0] init_byte(input logic [3:0] step);
        return step < 4'd3 ? {INIT_NIB_8BIT, 4'h0} :
               step == 4'd3 ? {INIT_NIB_4BIT, 4'h0} :
               step == 4'd4 ? CMD_FUNC_SET :
               step == 4'd5 ? CMD_DISP_ON :
               step == 4'd6 ? CMD_ENTRY : CMD_CLEAR;
    endfunction

    // Clear and home are the only commands that need the long post-byte wait
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] b);
        return !rs && (b == CMD_CLEAR || b == CMD_HOME);
    endfunction

endpackage

// File: rtl/lcd_i2c_controller_if.sv
// lcd_i2c_controller_if: upstream byte handshake plus the I2C master byte interface
interface lcd_i2c_controller_if;
    logic [7:0] lcd_data_in;
    logic       lcd_write_char;
    logic       lcd_write_cmd;
    logic       lcd_ready_out;
    logic [7:0] i2c_data_out;
    logic       i2c_start;
    logic       i2c_busy;

    modport master (
        output lcd_data_in, lcd_write_char, lcd_write_cmd, i2c_busy,
        input  lcd_ready_out, i2c_data_out, i2c_start
    );

    modport slave (
        input  lcd_data_in, lcd_write_char, lcd_write_cmd, i2c_busy,
        output lcd_ready_out, i2c_data_out, i2c_start
    );
endinterface

// File: rtl/lcd_us_timer.sv
// lcd_us_timer: loadable down-counter of 1 us ticks, expired while the count is zero
module lcd_us_timer #(
    parameter int CLK_HZ = 50_000_000,
    parameter int W      = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] us_count,
    output logic         expired
);
    localparam int DIV = CLK_HZ / 1_000_000 > 0 ? CLK_HZ / 1_000_000 : 1;
    localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;

    logic [PW-1:0] pre;
    logic [W-1:0]  cnt;
    logic          tick;

    assign tick    = pre == PW'(DIV - 1);
    assign expired = cnt == '0 && !load;

    // Prescaler restarts on load so every wait is a whole number of microseconds
    always_ff @(posedge clock) begin
        if (reset) begin
            pre <= '0;
            cnt <= '0;
        end else if (load) begin
            pre <= '0;
            cnt <= us_count;
        end else if (cnt != '0) begin
            pre <= tick ? '0 : pre + PW'(1);
            if (tick) cnt <= cnt - W'(1);
        end
    end
endmodule

// File: rtl/lcd_i2c_controller.sv
// lcd_i2c_controller: HD44780 4-bit init and byte transmit through a PCF8574 I2C expander
module lcd_i2c_controller
    import lcd_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int POWERUP_US = 50_000,
    parameter int INIT1_US   = 4_100,
    parameter int INIT2_US   = 100,
    parameter int CMD_US     = 50,
    parameter int CLEAR_US   = 2_000
) (
    input  logic                 clock,
    input  logic                 reset,
    lcd_i2c_controller_if.slave  bus,
    output logic                 init_done
);
    localparam int W = $clog2(POWERUP_US + 1);

    top_state_t  state, state_n;
    nib_state_t  sub, sub_n;
    logic [3:0]  step, step_n;
    logic [7:0]  byte_q, byte_n, init_b, frame;
    logic        rs_q, rs_n, nib_only, nib_only_n, low_half, low_half_n;
    logic        init_done_n, load_q, expired, ready, accept, start;
    logic [W-1:0] delay_us, delay_n;

    assign ready             = state == IDLE && init_done;
    assign accept            = ready && (bus.lcd_write_char || bus.lcd_write_cmd);
    assign init_b            = init_byte(step);
    assign bus.lcd_ready_out = ready;
    assign bus.i2c_start     = start;
    assign bus.i2c_data_out  = frame;

    lcd_us_timer #(.CLK_HZ(CLK_HZ), .W(W)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (load_q),
        .us_count (state == PWR_WAIT ? W'(POWERUP_US) : delay_us),
        .expired  (expired)
    );

    // Frame on the expander pins: backlight always on, write mode, EN high for the first half of a nibble
    always_comb begin
        frame = '0;
        frame[FRAME_BL] = 1'b1;
        if (state == SEND) begin
            frame[7:4] = low_half ? byte_q[3:0] : byte_q[7:4];
            frame[FRAME_EN] = sub == NIB_HI || sub == ACK_HI || sub == DONE_HI;
            frame[FRAME_RS] = rs_q;
        end
    end

    // Next-state logic for the top sequence and the nibble handshake with the I2C master
    always_comb begin
        state_n     = state;
        sub_n       = sub;
        step_n      = step;
        byte_n      = byte_q;
        rs_n        = rs_q;
        nib_only_n  = nib_only;
        low_half_n  = low_half;
        delay_n     = delay_us;
        init_done_n = init_done;
        start       = 1'b0;
        case (state)
            PWR_WAIT: if (expired) state_n = INIT;
            INIT: begin
                if (step == 4'd8) begin
                    init_done_n = 1'b1;
                    state_n     = IDLE;
                end else begin
                    byte_n     = init_b;
                    rs_n       = 1'b0;
                    nib_only_n = step < 4'd4;
                    delay_n    = step == 4'd0 ? W'(INIT1_US) :
                                 step < 4'd4 ? W'(INIT2_US) :
                                 is_slow_cmd(1'b0, init_b) ? W'(CLEAR_US) : W'(CMD_US);
                    step_n     = step + 4'd1;
                    low_half_n = 1'b0;
                    sub_n      = NIB_HI;
                    state_n    = SEND;
                end
            end
            IDLE: begin
                if (accept) begin
                    byte_n     = bus.lcd_data_in;
                    rs_n       = !bus.lcd_write_cmd;
                    nib_only_n = 1'b0;
                    delay_n    = is_slow_cmd(!bus.lcd_write_cmd, bus.lcd_data_in) ? W'(CLEAR_US) : W'(CMD_US);
                    low_half_n = 1'b0;
                    sub_n      = NIB_HI;
                    state_n    = SEND;
                end
            end
            SEND: begin
                case (sub)
                    NIB_HI: if (!bus.i2c_busy) begin
                        start = 1'b1;
                        sub_n = ACK_HI;
                    end
                    ACK_HI:  if (bus.i2c_busy) sub_n = DONE_HI;
                    DONE_HI: if (!bus.i2c_busy) sub_n = NIB_LO;
                    NIB_LO: if (!bus.i2c_busy) begin
                        start = 1'b1;
                        sub_n = ACK_LO;
                    end
                    ACK_LO:  if (bus.i2c_busy) sub_n = DONE_LO;
                    DONE_LO: if (!bus.i2c_busy) begin
                        if (low_half || nib_only) state_n = DELAY;
                        else begin
                            low_half_n = 1'b1;
                            sub_n      = NIB_HI;
                        end
                    end
                    default: sub_n = NIB_HI;
                endcase
            end
            DELAY: if (expired) state_n = init_done ? IDLE : INIT;
            default: state_n = PWR_WAIT;
        endcase
    end

    // State registers; load_q reloads the timer on the first cycle of PWR_WAIT and DELAY
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= PWR_WAIT;
            sub       <= NIB_HI;
            step      <= '0;
            byte_q    <= '0;
            rs_q      <= 1'b0;
            nib_only  <= 1'b0;
            low_half  <= 1'b0;
            delay_us  <= '0;
            init_done <= 1'b0;
            load_q    <= 1'b1;
        end else begin
            state     <= state_n;
            sub       <= sub_n;
            step      <= step_n;
            byte_q    <= byte_n;
            rs_q      <= rs_n;
            nib_only  <= nib_only_n;
            low_half  <= low_half_n;
            delay_us  <= delay_n;
            init_done <= init_done_n;
            load_q    <= state_n == DELAY && state != DELAY;
        end
    end
endmodule
